// File: rtl/llc_set_wb_pkg.sv
// Shared LLC cache field widths, types and the write-back FSM state encoding.
package llc_set_wb_pkg;

  localparam int LLC_WAYS     = 16;
  localparam int WAY_BITS     = 4;
  localparam int SET_BITS     = 10;
  localparam int LINE_BITS    = 128;
  localparam int TAG_BITS     = 16;
  localparam int STATE_BITS   = 3;
  localparam int OWNER_BITS   = 4;
  localparam int SHARERS_BITS = 16;
  localparam int HPROT_BITS   = 1;

  typedef logic [LINE_BITS-1:0]    line_t;
  typedef logic [TAG_BITS-1:0]     llc_tag_t;
  typedef logic [STATE_BITS-1:0]   llc_state_t;
  typedef logic [OWNER_BITS-1:0]   owner_t;
  typedef logic [SHARERS_BITS-1:0] sharers_t;
  typedef logic [HPROT_BITS-1:0]   hprot_t;
  typedef logic [WAY_BITS-1:0]     llc_way_t;
  typedef logic [SET_BITS-1:0]     llc_set_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINES = 2'd1,
    ST_EVICT = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/llc_set_wb_prio_enc.sv
// Lowest-set-bit encoder: picks the lowest modified way still pending write-back.
module llc_way_prio_enc import llc_set_wb_pkg::*; #(
  parameter int N_WAYS = LLC_WAYS,
  parameter int W_BITS = WAY_BITS
) (
  input  logic [N_WAYS-1:0] i_mask,
  output logic [W_BITS-1:0] o_way,
  output logic              o_any
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    o_way = '0;
    o_any = 1'b0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_way = W_BITS'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_set_wb.sv
// LLC set write-back: after a set update, streams each modified way (lowest
// first) to local memory, then optionally the evict pointer, then pulses done.
module llc_set_wb import llc_set_wb_pkg::*; (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rst_state,
  input  logic                              start,
  input  llc_set_t                          set_in,
  input  logic [LLC_WAYS-1:0]               mod_mask,
  input  logic                              evict_upd,
  input  llc_way_t                          evict_way_buf,
  input  logic [LLC_WAYS*LINE_BITS-1:0]     lines_buf,
  input  logic [LLC_WAYS*TAG_BITS-1:0]      tags_buf,
  input  logic [LLC_WAYS*STATE_BITS-1:0]    states_buf,
  input  logic [LLC_WAYS*OWNER_BITS-1:0]    owners_buf,
  input  logic [LLC_WAYS*SHARERS_BITS-1:0]  sharers_buf,
  input  logic [LLC_WAYS*HPROT_BITS-1:0]    hprots_buf,
  input  logic [LLC_WAYS-1:0]               dirty_bits_buf,
  input  logic                              wr_ready,
  output logic                              wr_valid,
  output logic                              wr_evict_valid,
  output llc_set_t                          wr_set,
  output llc_way_t                          wr_way,
  output line_t                             wr_line,
  output llc_tag_t                          wr_tag,
  output llc_state_t                        wr_state,
  output owner_t                            wr_owner,
  output sharers_t                          wr_sharers,
  output hprot_t                            wr_hprot,
  output logic                              wr_dirty,
  output llc_way_t                          wr_evict_way,
  output logic                              busy,
  output logic                              done
);

  wb_state_t           r_state, w_state_nxt;
  logic [LLC_WAYS-1:0] r_mask, w_mask_nxt;
  llc_set_t            r_set, w_set_nxt;
  logic                r_evict, w_evict_nxt;

  llc_way_t            w_enc_way;
  logic                w_enc_any;
  logic [LLC_WAYS-1:0] w_mask_clr;
  logic                w_in_lines;

  llc_way_prio_enc #(
    .N_WAYS (LLC_WAYS),
    .W_BITS (WAY_BITS)
  ) u_prio_enc (
    .i_mask (r_mask),
    .o_way  (w_enc_way),
    .o_any  (w_enc_any)
  );

  // Mask left over once the way currently on the bus is accepted.
  assign w_mask_clr = r_mask & ~(LLC_WAYS'(1) << w_enc_way);
  assign w_in_lines = (r_state == ST_LINES) && w_enc_any;

  // State and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_set   <= '0;
      r_evict <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_set   <= w_set_nxt;
      r_evict <= w_evict_nxt;
    end
  end

  // Next-state logic; rst_state overrides everything, including a start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_set_nxt   = r_set;
    w_evict_nxt = r_evict;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_set_nxt   = set_in;
          w_mask_nxt  = mod_mask;
          w_evict_nxt = evict_upd;
          if (mod_mask != '0)  w_state_nxt = ST_LINES;
          else if (evict_upd)  w_state_nxt = ST_EVICT;
          else                 w_state_nxt = ST_DONE;
        end
      end
      ST_LINES: begin
        if (!w_enc_any) begin
          w_state_nxt = r_evict ? ST_EVICT : ST_DONE;
        end else if (wr_ready) begin
          w_mask_nxt = w_mask_clr;
          if (w_mask_clr == '0) w_state_nxt = r_evict ? ST_EVICT : ST_DONE;
        end
      end
      ST_EVICT: begin
        if (wr_ready) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (rst_state) begin
      w_state_nxt = ST_IDLE;
      w_mask_nxt  = '0;
      w_evict_nxt = 1'b0;
      w_set_nxt   = r_set;
    end
  end

  // Beat data: mux the selected way's fields; zero outside LINES.
  always_comb begin
    wr_line    = '0;
    wr_tag     = '0;
    wr_state   = '0;
    wr_owner   = '0;
    wr_sharers = '0;
    wr_hprot   = '0;
    wr_dirty   = 1'b0;
    if (w_in_lines) begin
      for (int i = 0; i < LLC_WAYS; i++) begin
        if (w_enc_way == WAY_BITS'(i)) begin
          wr_line    = lines_buf[i*LINE_BITS +: LINE_BITS];
          wr_tag     = tags_buf[i*TAG_BITS +: TAG_BITS];
          wr_state   = states_buf[i*STATE_BITS +: STATE_BITS];
          wr_owner   = owners_buf[i*OWNER_BITS +: OWNER_BITS];
          wr_sharers = sharers_buf[i*SHARERS_BITS +: SHARERS_BITS];
          wr_hprot   = hprots_buf[i*HPROT_BITS +: HPROT_BITS];
          wr_dirty   = dirty_bits_buf[i];
        end
      end
    end
  end

  assign wr_valid       = w_in_lines;
  assign wr_way         = w_in_lines ? w_enc_way : '0;
  assign wr_evict_valid = (r_state == ST_EVICT);
  assign wr_evict_way   = (r_state == ST_EVICT) ? evict_way_buf : '0;
  assign wr_set         = r_set;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE) && !rst_state;

endmodule

// File: doc/llc_set_wb.md
Name: llc_set_wb

Overview:
- Write-back stage directly downstream of the LLC per-set buffer block.
- After a request finishes updating a set in the way buffers, it walks the modified ways one at a time, lowest way first.
- Each modified way is written back to LLC local memory as one beat carrying line, tag, state, owner, sharers, hprot and dirty bit.
- If the eviction pointer changed, one final beat writes evict_way. A done pulse is then returned to the LLC control FSM.

Parameters:
- LLC_WAYS, 16, number of ways per set (power of 2, ≥ 2)
- WAY_BITS, 4, log2(LLC_WAYS)
- SET_BITS, 10, set-index width
- LINE_BITS, 128, bits per cache line
- TAG_BITS, 16, tag width
- STATE_BITS, 3, LLC state width
- OWNER_BITS, 4, owner id width
- SHARERS_BITS, 16, sharers vector width
- HPROT_BITS, 1, hprot width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rst_state  in  1  synchronous abort/clear
- start  in  1  begin write-back of the current set (pulse)
- set_in  in  SET_BITS  set index to write
- mod_mask  in  LLC_WAYS  per-way modified flags, bit i = way i
- evict_upd  in  1  evict pointer changed, write it back
- evict_way_buf  in  WAY_BITS  evict pointer from buffers
- lines_buf / tags_buf / states_buf / owners_buf / sharers_buf / hprots_buf / dirty_bits_buf  in  LLC_WAYS×field width each  buffer contents, flattened, way 0 at LSBs
- wr_ready  in  1  local memory accepts beat
- wr_valid  out  1  line beat valid
- wr_evict_valid  out  1  evict-way beat valid
- wr_set  out  SET_BITS  captured set index
- wr_way  out  WAY_BITS  way being written
- wr_line / wr_tag / wr_state / wr_owner / wr_sharers / wr_hprot / wr_dirty  out  field widths  selected way's data
- wr_evict_way  out  WAY_BITS  evict pointer
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, async): state IDLE; mask_q=0, set_q=0, evict_q=0. All outputs 0.
- FSM states: IDLE, LINES, EVICT, DONE.
- IDLE, on start: capture set_q←set_in, mask_q←mod_mask, evict_q←evict_upd.
  - Next state LINES if mod_mask≠0; else EVICT if evict_upd; else DONE.
- start while busy: ignored, no capture.
- LINES:
  - wr_valid=1; wr_way = index of lowest set bit in mask_q.
  - Data outputs are a mux of the buffer inputs at wr_way. Buffers must be held stable while busy.
  - On wr_valid & wr_ready: clear that bit in mask_q.
  - If that was the last bit: go to EVICT if evict_q, else DONE.
  - wr_ready low: hold all outputs unchanged.
- EVICT:
  - wr_evict_valid=1; wr_evict_way=evict_way_buf.
  - On wr_ready: go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in LINES/EVICT/DONE.
- wr_valid and wr_evict_valid are never high together.
- Latency with wr_ready held high:
  - start at cycle 0; first beat at cycle 1.
  - N modified ways give N consecutive beats; +1 beat if evict_q.
  - done in the cycle after the last beat.
  - Empty mask and no evict: done at cycle 1.
- rst_state (any state): synchronous return to IDLE, mask_q=0, evict_q=0, no done pulse. Takes priority over start and wr_ready in the same cycle.
- wr_set stays stable from capture until return to IDLE.

Decomposition:
- Field widths and state encodings come from the shared cache_consts/cache_types package (line_t, llc_tag_t, llc_state_t, owner_t, sharers_t, hprot_t, llc_way_t, llc_set_t). No new typedefs.
- One sub-module: llc_way_prio_enc, a combinational lowest-set-bit encoder. Inputs: LLC_WAYS mask. Outputs: way index and any-set flag.

Test Plan:
- mod_mask=0x0005, evict_upd=0, wr_ready=1, start at cycle 0 -> wr_valid cycles 1–2 with wr_way=0 then 2; done at cycle 3; busy low at cycle 4.
- mod_mask=0x8000, wr_ready low for 3 cycles -> wr_valid held with wr_way=15 and stable data; beat accepted on first ready; done the next cycle.
- mod_mask=0, evict_upd=1, evict_way_buf=7 -> wr_evict_valid at cycle 1 with wr_evict_way=7; done at cycle 2; wr_valid never asserted.
- mod_mask=0, evict_upd=0 -> done at cycle 1; no write beats.
- mod_mask=0xFFFF, rst_state pulsed after 4 accepted beats -> IDLE the next cycle, no done pulse; a new start with mask 0x0002 writes only way 1.
- start re-pulsed during LINES with different set_in/mod_mask -> ignored; wr_set and remaining beats unchanged.
